// File: rtl/bep_frame_ctrl.sv
// Bit-stream frame controller: hunts for a preamble, collects a 1..16 bit payload,
// then holds it for a ready/valid handshake while tracking overrun and timeout errors.
module bep_frame_ctrl #(
    parameter logic [7:0] PREAMBLE = 8'hD5,
    parameter int         TIMEOUT  = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        bit_valid,
    input  logic        bit_data,
    input  logic        line_err,
    input  logic [3:0]  frame_len,
    output logic [15:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        err_clr,
    output logic [1:0]  state
);
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

    typedef enum logic [1:0] {HUNT = 2'd0, COLLECT = 2'd1, HOLD = 2'd2} state_t;

    state_t          st_q;
    logic [7:0]      hunt_q;
    logic [4:0]      bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [3:0]      len_q;
    logic [7:0]      hunt_nxt;

    assign hunt_nxt = {hunt_q[6:0], bit_data};
    assign state    = st_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= HUNT;
            hunt_q      <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            len_q       <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else if (ena) begin
            // Clear first so a set event later in this block wins.
            if (err_clr) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end
            case (st_q)
                HUNT: begin
                    if (line_err) begin
                        hunt_q <= '0;
                    end else if (bit_valid) begin
                        if (hunt_nxt == PREAMBLE) begin
                            st_q       <= COLLECT;
                            hunt_q     <= '0;
                            bit_cnt    <= '0;
                            gap_cnt    <= '0;
                            frame_data <= '0;
                            len_q      <= frame_len;
                        end else begin
                            hunt_q <= hunt_nxt;
                        end
                    end
                end
                COLLECT: begin
                    if (line_err) begin
                        st_q   <= HUNT;
                        hunt_q <= '0;
                    end else if (bit_valid) begin
                        frame_data <= {frame_data[14:0], bit_data};
                        bit_cnt    <= bit_cnt + 5'd1;
                        gap_cnt    <= '0;
                        // Count before this bit equal to len means this is bit len+1.
                        if (bit_cnt == {1'b0, len_q}) begin
                            st_q        <= HOLD;
                            frame_valid <= 1'b1;
                        end
                    end else if (gap_cnt == GAP_MAX) begin
                        st_q        <= HUNT;
                        hunt_q      <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        st_q        <= HUNT;
                        frame_valid <= 1'b0;
                        hunt_q      <= bit_valid ? {7'd0, bit_data} : 8'd0;
                    end else if (bit_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    st_q        <= HUNT;
                    hunt_q      <= '0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bep_frame_ctrl.sv
// Directed bench for bep_frame_ctrl: a vector table for the basic frame and preamble
// corner cases, then hand sequences for hold/overrun, timeout, abort, enable and reset.
module tb_bep_frame_ctrl;
    logic        clk = 1'b0, rst = 1'b0, ena = 1'b1;
    logic        bit_valid = 1'b0, bit_data = 1'b0, line_err = 1'b0;
    logic        frame_ready = 1'b0, err_clr = 1'b0;
    logic [3:0]  frame_len = 4'd7;
    logic [15:0] frame_data;
    logic        frame_valid, overrun, timeout_err;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    bep_frame_ctrl dut (
        .clk(clk), .rst(rst), .ena(ena), .bit_valid(bit_valid), .bit_data(bit_data),
        .line_err(line_err), .frame_len(frame_len), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun),
        .timeout_err(timeout_err), .err_clr(err_clr), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bv, bd, le, fr;
        logic [1:0]  st;
        logic        fv;
        logic [15:0] data;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic bv, bd, le, fr, input logic [1:0] st,
                       input logic fv, input logic [15:0] data);
        vec_t v;
        v.bv = bv; v.bd = bd; v.le = le; v.fr = fr; v.st = st; v.fv = fv; v.data = data;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Packed view {state, fv, data, ov, to} for whole-output comparisons.
    task automatic chk_out(input string name, input logic [1:0] st, input logic fv,
                           input logic [15:0] data, input logic ov, input logic to);
        chk(name, {11'd0, state, frame_valid, frame_data, overrun, timeout_err},
                  {11'd0, st, fv, data, ov, to});
    endtask

    task automatic cyc(input logic bv, input logic bd, input logic le, input logic fr);
        bit_valid = bv; bit_data = bd; line_err = le; frame_ready = fr;
        @(posedge clk);
        #1;
        bit_valid = 1'b0; line_err = 1'b0;
    endtask

    task automatic send(input logic [15:0] val, input int n, input logic fr);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, val[i], 1'b0, fr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b1;
        #1 chk_out("reset_state", 2'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame D5 + 1010_0110, len 7, ready high.
        add(1,1,0,1, 0,0,16'h0); add(1,1,0,1, 0,0,16'h0); add(1,0,0,1, 0,0,16'h0);
        add(1,1,0,1, 0,0,16'h0); add(1,0,0,1, 0,0,16'h0); add(1,1,0,1, 0,0,16'h0);
        add(1,0,0,1, 0,0,16'h0); add(1,1,0,1, 1,0,16'h0);
        add(1,1,0,1, 1,0,16'h01); add(1,0,0,1, 1,0,16'h02); add(1,1,0,1, 1,0,16'h05);
        add(1,0,0,1, 1,0,16'h0A); add(1,0,0,1, 1,0,16'h14); add(1,1,0,1, 1,0,16'h29);
        add(1,1,0,1, 1,0,16'h53); add(1,0,0,1, 2,1,16'hA6);
        add(0,0,0,1, 0,0,16'hA6);
        // Near-miss D4 stays in HUNT.
        add(1,1,0,0, 0,0,16'hA6); add(1,1,0,0, 0,0,16'hA6); add(1,0,0,0, 0,0,16'hA6);
        add(1,1,0,0, 0,0,16'hA6); add(1,0,0,0, 0,0,16'hA6); add(1,1,0,0, 0,0,16'hA6);
        add(1,0,0,0, 0,0,16'hA6); add(1,0,0,0, 0,0,16'hA6);
        // 7 bits that would complete D5 on a final 1; line_err must win over it.
        add(1,1,0,0, 0,0,16'hA6); add(1,1,0,0, 0,0,16'hA6); add(1,0,0,0, 0,0,16'hA6);
        add(1,1,0,0, 0,0,16'hA6); add(1,0,0,0, 0,0,16'hA6); add(1,1,0,0, 0,0,16'hA6);
        add(1,0,0,0, 0,0,16'hA6);
        add(1,1,1,0, 0,0,16'hA6); add(1,1,0,0, 0,0,16'hA6);

        foreach (tv[i]) begin
            cyc(tv[i].bv, tv[i].bd, tv[i].le, tv[i].fr);
            chk_out($sformatf("vec%0d", i), tv[i].st, tv[i].fv, tv[i].data, 1'b0, 1'b0);
        end

        // 16-bit frame held with ready low; extra bits raise overrun.
        frame_len = 4'd15;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h00D5, 8, 1'b0);
        send(16'hBEEF, 16, 1'b0);
        chk_out("hold16_enter", 2'd2, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cyc(0,0,0,0); cyc(1,1,0,0); cyc(0,0,0,0); cyc(1,0,0,0); cyc(0,0,0,0);
        chk_out("hold16_overrun", 2'd2, 1'b1, 16'hBEEF, 1'b1, 1'b0);
        err_clr = 1'b1;
        cyc(1,0,0,0);
        chk_out("clr_vs_set", 2'd2, 1'b1, 16'hBEEF, 1'b1, 1'b0);
        cyc(0,0,0,0);
        err_clr = 1'b0;
        chk_out("err_clr", 2'd2, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        cyc(1,1,0,1);
        chk_out("handshake_bit", 2'd0, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        // The handshake bit seeded the hunt register with 1; 7 more complete D5.
        send(16'h0055, 7, 1'b0);
        chk("handshake_bit_kept", state, 2'd1);
        cyc(0,0,1,0);
        chk("collect_abort", state, 2'd0);

        // Timeout: preamble, 3 bits, then idle.
        frame_len = 4'd7;
        send(16'h00D5, 8, 1'b0);
        send(16'h0005, 3, 1'b0);
        repeat (199) cyc(0,0,0,0);
        chk("gap_199", state, 2'd1);
        cyc(0,0,0,0);
        chk("timeout_state", state, 2'd0);
        chk("timeout_flag", {frame_valid, timeout_err}, 2'b01);
        send(16'h00D5, 8, 1'b1);
        send(16'h003C, 8, 1'b1);
        chk_out("post_timeout_frame", 2'd2, 1'b1, 16'h003C, 1'b0, 1'b1);
        cyc(0,0,0,1);
        chk("post_timeout_done", {state, frame_valid}, 3'b000);
        err_clr = 1'b1;
        cyc(0,0,0,0);
        err_clr = 1'b0;
        chk("timeout_clr", timeout_err, 1'b0);

        // Abort by line_err after 2 payload bits.
        send(16'h00D5, 8, 1'b1);
        send(16'h0003, 2, 1'b1);
        cyc(0,0,1,1);
        chk("abort_state", {state, frame_valid, overrun, timeout_err}, 5'b0);
        repeat (6) cyc(1,1,0,1);
        chk("abort_no_frame", {state, frame_valid}, 3'b000);
        cyc(0,0,1,0);

        // Enable low freezes a held frame even with ready and bits present.
        send(16'h00D5, 8, 1'b0);
        send(16'h0081, 8, 1'b0);
        chk_out("ena_hold", 2'd2, 1'b1, 16'h0081, 1'b0, 1'b0);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1,1,1,1);
            chk_out($sformatf("ena_low%0d", i), 2'd2, 1'b1, 16'h0081, 1'b0, 1'b0);
        end
        ena = 1'b1;
        cyc(0,0,0,1);
        chk("ena_release", {state, frame_valid}, 3'b000);

        // Reset pulse between edges mid-COLLECT.
        send(16'h00D5, 8, 1'b0);
        send(16'h0007, 3, 1'b0);
        chk("pre_rst_data", frame_data, 16'h0007);
        #3 rst = 1'b1;
        #1 chk_out("rst_collect", 2'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        send(16'h0015, 5, 1'b1);
        chk("rst_no_frame", {state, frame_valid}, 3'b000);
        cyc(0,0,1,0);
        send(16'h00D5, 8, 1'b0);
        chk("rst_first_bit", state, 2'd1);
        send(16'h00FF, 8, 1'b0);
        chk("hold_before_rst", frame_valid, 1'b1);
        #3 rst = 1'b1;
        #1 chk_out("rst_hold", 2'd0, 1'b0, 16'h0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        cyc(0,0,0,0);
        chk("rst_hold_after", {state, frame_valid}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bep_frame_ctrl.md
BEP_FRAME_CTRL -- requirements
Module: bep_frame_ctrl

Interface
REQ-001 Parameter PREAMBLE, default 8'hD5: sync pattern that opens every frame.
REQ-002 Parameter TIMEOUT, default 200: maximum clk cycles allowed between payload bits.
REQ-003 clk  in  1  sole clock, rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ena  in  1  global enable; low freezes the block.
REQ-006 bit_valid  in  1  single-cycle strobe from the line decoder marking one decoded bit.
REQ-007 bit_data  in  1  decoded bit value, qualified by bit_valid.
REQ-008 line_err  in  1  decoder flag for an illegal transition.
REQ-009 frame_len  in  4  payload length minus one (1..16 bits), sampled on entry to COLLECT.
REQ-010 frame_data  out  16  assembled payload, right-justified, unused upper bits zero.
REQ-011 frame_valid  out  1  frame available.
REQ-012 frame_ready  in  1  downstream accepts the frame.
REQ-013 overrun  out  1  sticky: bit dropped while a frame was held.
REQ-014 timeout_err  out  1  sticky: inter-bit gap exceeded TIMEOUT.
REQ-015 err_clr  in  1  clears both sticky flags.
REQ-016 state  out  2  FSM state: 0 HUNT, 1 COLLECT, 2 HOLD.

Function
REQ-017 States SHALL be HUNT, COLLECT and HOLD; encoding 3 is illegal and SHALL return to HUNT on the next cycle.
REQ-018 HUNT: each accepted bit_valid SHALL shift bit_data into an 8-bit hunt register, MSB-first, new bit entering at bit 0.
REQ-019 HUNT: when the post-shift hunt register equals PREAMBLE, the FSM SHALL enter COLLECT on the next edge, clear the bit counter, the gap counter and frame_data, and latch frame_len.
REQ-020 HUNT: line_err SHALL clear the hunt register; line_err takes precedence over a bit_valid in the same cycle.
REQ-021 COLLECT: each bit_valid SHALL update frame_data <= {frame_data[14:0], bit_data} and increment the bit counter.
REQ-022 COLLECT: the bit that makes the count equal latched frame_len+1 SHALL move the FSM to HOLD, with frame_valid high on the next cycle.
REQ-023 COLLECT: line_err SHALL abort to HUNT with the hunt register cleared; no frame is emitted and no flag is set.
REQ-024 COLLECT: the gap counter SHALL increment on every enabled cycle without bit_valid and clear on bit_valid.
REQ-025 COLLECT: when the gap counter reaches TIMEOUT, the FSM SHALL enter HUNT, set timeout_err and clear the hunt register.
REQ-026 HOLD: frame_valid SHALL be high and frame_data stable until a cycle with frame_valid and frame_ready both high; the FSM then enters HUNT.
REQ-027 HOLD: a bit_valid without handshake SHALL be dropped and SHALL set overrun.
REQ-028 HOLD: a bit_valid in the handshake cycle SHALL be shifted into the cleared hunt register and SHALL NOT set overrun.
REQ-029 line_err in HOLD SHALL be ignored.
REQ-030 frame_valid SHALL be high only in HOLD; it SHALL NOT depend combinationally on frame_ready.
REQ-031 ena low: state, counters and registers SHALL hold; bit_valid, line_err and frame_ready SHALL be ignored; outputs SHALL keep their values.
REQ-032 err_clr SHALL clear overrun and timeout_err next cycle; a set event in the same cycle SHALL win.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst high SHALL immediately force state HUNT, frame_valid 0, frame_data 0, overrun 0, timeout_err 0, and clear the hunt register and all counters, regardless of clk or ena.
REQ-035 Reset asserted mid-COLLECT or mid-HOLD SHALL discard the partial or held frame; no frame_valid after release.
REQ-036 After rst deasserts, the first accepted bit SHALL be processed on the next clk edge.

Verification
REQ-037 Bits D5 then 8 payload bits 1010_0110 with frame_len=7, frame_ready=1 -> frame_valid for one cycle with frame_data 16'h00A6, state back to 0.
REQ-038 Preamble, frame_len=15, 16 bits, frame_ready=0 for 5 cycles with 2 extra bit_valid -> frame_data held, overrun=1; err_clr -> overrun=0.
REQ-039 Preamble then 3 bits then 200 idle cycles -> timeout_err=1, state=0, no frame_valid; a following clean frame decodes correctly.
REQ-040 Preamble, 2 bits, line_err -> state=0, no frame, flags 0; near-miss 8'hD4 stream -> stays in HUNT.
REQ-041 Frame held, ena low 10 cycles with frame_ready=1 -> frame_valid stays 1; ena high -> transfer next cycle.
REQ-042 rst pulse mid-COLLECT between clk edges -> outputs zero immediately, state 0, no spurious frame.
